// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite to APB4 bridge: one APB transfer per accepted AHB address phase.
// Optional APB_TIMEOUT_EN adds a PREADY-low watchdog that ends the transfer with an error.
module ahbl_apb_bridge #(
  parameter int PADDR_W        = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic [31:0]        HRDATA,
  output logic               HRESP,
  output logic [PADDR_W-1:0] PADDR,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PWDATA,
  output logic [3:0]         PSTRB,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_t;

  state_t state_r;
  state_t state_next_s;
  state_t start_state_s;
  logic   accept_s;
  logic   take_s;
  logic   timeout_s;
  logic   unused_s;

  function automatic logic [3:0] calc_strb(input logic write, input logic [2:0] size,
                                           input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      3'd0:    strb = 4'b0001 << addr;
      3'd1:    strb = 4'b0011 << {addr[1], 1'b0};
      3'd2:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return write ? strb : 4'b0000;
  endfunction

  assign accept_s      = HSEL & HTRANS[1] & HREADY;
  assign start_state_s = (HSIZE > 3'd2) ? ST_ERR1 : ST_SETUP;
  assign PWDATA        = HWDATA;
  assign unused_s      = ^{HADDR, HTRANS[0]};

  // Next-state decode; take_s marks the cycles where a new address phase may be captured
  always_comb begin
    state_next_s = state_r;
    take_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        take_s       = accept_s;
        state_next_s = accept_s ? start_state_s : ST_IDLE;
      end
      ST_SETUP: begin
        state_next_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            state_next_s = ST_ERR1;
          end else begin
            take_s       = accept_s;
            state_next_s = accept_s ? start_state_s : ST_IDLE;
          end
        end else if (timeout_s) begin
          state_next_s = ST_ERR1;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_ERR1: begin
        state_next_s = ST_ERR2;
      end
      ST_ERR2: begin
        take_s       = accept_s;
        state_next_s = accept_s ? start_state_s : ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register and APB request capture
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r <= ST_IDLE;
      PADDR   <= {PADDR_W{1'b0}};
      PWRITE  <= 1'b0;
      PSTRB   <= 4'b0000;
    end else begin
      state_r <= state_next_s;
      if (take_s) begin
        PADDR  <= HADDR[PADDR_W-1:0];
        PWRITE <= HWRITE;
        PSTRB  <= calc_strb(HWRITE, HSIZE, HADDR[1:0]);
      end else begin
        PADDR  <= PADDR;
        PWRITE <= PWRITE;
        PSTRB  <= PSTRB;
      end
    end
  end

  // Bus-side outputs decoded from the current state
  always_comb begin
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        HREADYOUT = 1'b1;
      end
      ST_SETUP: begin
        PSEL      = 1'b1;
        HREADYOUT = 1'b0;
      end
      ST_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        HREADYOUT = PREADY & ~PSLVERR;
        HRDATA    = PRDATA;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt_r;

  // Counts ACCESS cycles spent waiting on PREADY; restarts for every transfer
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_SETUP) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && !PREADY) begin
      tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // This wait cycle is the TIMEOUT_CYCLES-th one
  assign timeout_s = (state_r == ST_ACCESS) && !PREADY &&
                     (tmo_cnt_r >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_c = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Randomised self-checking bench for ahbl_apb_bridge: a transaction-level model expands
// each AHB transfer into its expected per-cycle bus response.
module tb_ahbl_apb_bridge;
  localparam int PADDR_W = 16;
  localparam int TMO     = 4;

  logic HCLK = 1'b0;
  logic HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [3:0] PSTRB;
  logic [31:0] HADDR, HWDATA, HRDATA, PWDATA, PRDATA;
  logic [PADDR_W-1:0] PADDR;

  ahbl_apb_bridge #(.PADDR_W(PADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;
  // The splitter returns this slave's ready as the bus ready
  assign HREADY = HREADYOUT;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] code;  // {PSEL, PENABLE, HREADYOUT, HRESP}
    int apb_idx;
    int addr_idx;
    int data_idx;
    logic pready;
    logic pslverr;
  } cyc_t;

  cyc_t exp_q[$];
  logic        t_write[8];
  logic [31:0] t_addr[8];
  logic [2:0]  t_size[8];
  logic [31:0] t_wdata[8];
  logic [31:0] t_rdata[8];
  int          t_waits[8];
  logic        t_err[8];
  logic        t_tmo[8];

  function automatic cyc_t mk(input logic [3:0] code, input int apb, input int ai, input int di,
                              input logic rdy, input logic err);
    cyc_t c;
    c.code = code; c.apb_idx = apb; c.addr_idx = ai; c.data_idx = di;
    c.pready = rdy; c.pslverr = err;
    return c;
  endfunction

  function automatic logic [3:0] model_strb(input logic write, input logic [2:0] size,
                                            input logic [31:0] addr);
    int bytes, lane;
    if (!write || size > 3'd2) return 4'b0000;
    bytes = 1 << size;
    lane  = int'(addr % 4) - (int'(addr % 4) % bytes);
    return 4'(((1 << bytes) - 1) << lane);
  endfunction

  task automatic set_t(input int i, input logic w, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] wd, input logic [31:0] rd, input int wt, input logic e);
    t_write[i] = w; t_addr[i] = a; t_size[i] = s; t_wdata[i] = wd; t_rdata[i] = rd;
    t_waits[i] = wt; t_err[i] = e; t_tmo[i] = 1'b0;
  endtask

  task automatic build(input int n);
    int nx;
    exp_q.delete();
    exp_q.push_back(mk(4'b0010, -1, 0, -1, 1'b0, 1'b0));
    for (int i = 0; i < n; i++) begin
      nx = (i + 1 < n) ? i + 1 : -1;
      if (t_size[i] > 3'd2) begin
        exp_q.push_back(mk(4'b0001, -1, nx, i, 1'b0, 1'b0));
        exp_q.push_back(mk(4'b0011, -1, nx, i, 1'b0, 1'b0));
      end else begin
        exp_q.push_back(mk(4'b1000, i, nx, i, 1'b0, 1'b0));
        if (t_tmo[i]) begin
          for (int k = 0; k < TMO; k++) exp_q.push_back(mk(4'b1100, i, nx, i, 1'b0, 1'b0));
          exp_q.push_back(mk(4'b0001, -1, nx, i, 1'b0, 1'b0));
          exp_q.push_back(mk(4'b0011, -1, nx, i, 1'b0, 1'b0));
        end else begin
          for (int k = 0; k < t_waits[i]; k++) exp_q.push_back(mk(4'b1100, i, nx, i, 1'b0, 1'b0));
          if (t_err[i]) begin
            exp_q.push_back(mk(4'b1100, i, nx, i, 1'b1, 1'b1));
            exp_q.push_back(mk(4'b0001, -1, nx, i, 1'b0, 1'b0));
            exp_q.push_back(mk(4'b0011, -1, nx, i, 1'b0, 1'b0));
          end else begin
            exp_q.push_back(mk(4'b1110, i, nx, i, 1'b1, 1'b0));
          end
        end
      end
    end
    exp_q.push_back(mk(4'b0010, -1, -1, -1, 1'b0, 1'b0));
  endtask

  task automatic drive_noise();
    int r;
    r = $urandom_range(0, 2);
    HSEL   = (r != 0);
    HTRANS = (r == 0) ? 2'b10 : ((r == 1) ? 2'b00 : 2'b01);
    HADDR  = $urandom;
    HWRITE = 1'($urandom);
    HSIZE  = 3'($urandom);
  endtask

  // Plays the modelled cycle list; entered and left at posedge+1
  task automatic run_seq(input int n, input string name);
    cyc_t e;
    logic [3:0] got;
    logic [31:0] exp_rd;
    build(n);
    for (int c = 0; c < exp_q.size(); c++) begin
      e = exp_q[c];
      if (e.addr_idx >= 0) begin
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = t_addr[e.addr_idx];
        HWRITE = t_write[e.addr_idx]; HSIZE = t_size[e.addr_idx];
      end else begin
        drive_noise();
      end
      HWDATA  = (e.data_idx >= 0) ? t_wdata[e.data_idx] : $urandom;
      PRDATA  = (e.apb_idx >= 0) ? t_rdata[e.apb_idx] : ($urandom | 32'h1);
      PREADY  = e.pready;
      PSLVERR = e.pslverr;
      @(negedge HCLK);
      got = {PSEL, PENABLE, HREADYOUT, HRESP};
      checks++;
      if (got !== e.code) begin
        errors++;
        $display("FAIL %s status cyc %0d: got PSEL/PENABLE/HREADYOUT/HRESP=%b expected %b",
                 name, c, got, e.code);
      end
      if (e.code[2]) exp_rd = t_rdata[e.apb_idx];
      else exp_rd = 32'h0;
      checks++;
      if (HRDATA !== exp_rd) begin
        errors++;
        $display("FAIL %s HRDATA cyc %0d: got %h expected %h", name, c, HRDATA, exp_rd);
      end
      if (e.code[3]) begin
        checks++;
        if (PADDR !== t_addr[e.apb_idx][PADDR_W-1:0]) begin
          errors++;
          $display("FAIL %s PADDR cyc %0d: got %h expected %h", name, c, PADDR,
                   t_addr[e.apb_idx][PADDR_W-1:0]);
        end
        checks++;
        if (PWRITE !== t_write[e.apb_idx]) begin
          errors++;
          $display("FAIL %s PWRITE cyc %0d: got %b expected %b", name, c, PWRITE, t_write[e.apb_idx]);
        end
        checks++;
        if (PSTRB !== model_strb(t_write[e.apb_idx], t_size[e.apb_idx], t_addr[e.apb_idx])) begin
          errors++;
          $display("FAIL %s PSTRB cyc %0d: got %b expected %b", name, c, PSTRB,
                   model_strb(t_write[e.apb_idx], t_size[e.apb_idx], t_addr[e.apb_idx]));
        end
        checks++;
        if (PWDATA !== t_wdata[e.apb_idx]) begin
          errors++;
          $display("FAIL %s PWDATA cyc %0d: got %h expected %h", name, c, PWDATA, t_wdata[e.apb_idx]);
        end
      end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic check_idle_reset(input string name);
    checks++;
    if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
      errors++;
      $display("FAIL %s status: got %b expected 0010", name, {PSEL, PENABLE, HREADYOUT, HRESP});
    end
    checks++;
    if ({PADDR, PWRITE, PSTRB} !== '0) begin
      errors++;
      $display("FAIL %s regs: got PADDR=%h PWRITE=%b PSTRB=%b expected zeros", name, PADDR, PWRITE, PSTRB);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_1234; HWRITE = 1'b1;
    HSIZE = 3'd2; HWDATA = 32'h0; PRDATA = 32'h1; PREADY = 1'b1; PSLVERR = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    @(negedge HCLK);
    check_idle_reset("reset");
    @(posedge HCLK); #1;
    HRESET = 1'b0;
  endtask

  task automatic test_word_write();
    set_t(0, 1'b1, 32'h4000_0010, 3'd2, 32'hA5A5_5A5A, 32'h1357_9BDF, 0, 1'b0);
    run_seq(1, "word_write");
  endtask

  task automatic test_byte_half();
    set_t(0, 1'b1, 32'h4000_0003, 3'd0, 32'h1122_3344, 32'h0, 0, 1'b0);
    set_t(1, 1'b1, 32'h4000_0002, 3'd1, 32'h5566_7788, 32'h0, 0, 1'b0);
    run_seq(2, "byte_half");
  endtask

  task automatic test_read_wait();
    set_t(0, 1'b0, 32'h4000_0040, 3'd2, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    run_seq(1, "read_wait");
  endtask

  task automatic test_errors();
    set_t(0, 1'b0, 32'h4000_0080, 3'd2, 32'h0, 32'hCAFE_F00D, 0, 1'b1);
    set_t(1, 1'b1, 32'h4000_0084, 3'd3, 32'h0BAD_0BAD, 32'h0, 0, 1'b0);
    set_t(2, 1'b0, 32'h4000_0088, 3'd2, 32'h0, 32'h600D_600D, 1, 1'b0);
    run_seq(3, "errors");
  endtask

  task automatic test_back_to_back();
    set_t(0, 1'b0, 32'h4000_0100, 3'd2, 32'h0, 32'hAAAA_0001, 0, 1'b0);
    set_t(1, 1'b0, 32'h4000_0104, 3'd2, 32'h0, 32'hBBBB_0002, 0, 1'b0);
    run_seq(2, "back_to_back");
  endtask

  task automatic test_random();
    int n;
    for (int s = 0; s < 12; s++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        set_t(i, 1'($urandom), {4'h4, 28'($urandom)},
              ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2)),
              $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      end
      run_seq(n, "random");
    end
  endtask

  task automatic test_reset_mid();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0200; HWRITE = 1'b1; HSIZE = 3'd2;
    PREADY = 1'b0; PSLVERR = 1'b0;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HWDATA = 32'h1234_5678;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid access: got PSEL/PENABLE=%b expected 11", {PSEL, PENABLE});
    end
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check_idle_reset("reset_mid");
    @(posedge HCLK); #1;
    HRESET = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef APB_TIMEOUT_EN
    set_t(0, 1'b0, 32'h4000_0300, 3'd2, 32'h0, 32'h7777_8888, 0, 1'b0);
    t_tmo[0] = 1'b1;
    run_seq(1, "timeout");
    set_t(0, 1'b0, 32'h4000_0304, 3'd2, 32'h0, 32'h1111_2222, TMO - 1, 1'b0);
    set_t(1, 1'b1, 32'h4000_0308, 3'd2, 32'h3333_4444, 32'h0, TMO - 1, 1'b0);
    run_seq(2, "timeout_clear");
`else
    set_t(0, 1'b0, 32'h4000_0300, 3'd2, 32'h0, 32'h7777_8888, 10, 1'b0);
    run_seq(1, "long_wait");
`endif
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_half();
    test_read_wait();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    test_word_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahbl_apb_bridge.md
AHBL_APB_BRIDGE -- requirements
Module: ahbl_apb_bridge

Interface
REQ-001 SHALL have parameter PADDR_W, default 16: APB address width, PADDR = HADDR[PADDR_W-1:0] of the captured address phase.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: PREADY-low limit, used only under APB_TIMEOUT_EN.
REQ-003 SHALL have HCLK  input  1  sole clock; every register updates on the rising edge.
REQ-004 SHALL have HRESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have HSEL  input  1  slave select from the upstream splitter page decoder.
REQ-006 SHALL have HADDR  input  32, HTRANS  input  2, HWRITE  input  1, HSIZE  input  3, HWDATA  input  32: AHB-Lite request.
REQ-007 SHALL have HREADY  input  1  bus-level ready, as returned by the splitter.
REQ-008 SHALL have HREADYOUT  output  1, HRDATA  output  32, HRESP  output  1: AHB-Lite slave response.
REQ-009 SHALL have PADDR  output  PADDR_W, PSEL  output  1, PENABLE  output  1, PWRITE  output  1, PWDATA  output  32, PSTRB  output  4: APB4 request.
REQ-010 SHALL have PRDATA  input  32, PREADY  input  1, PSLVERR  input  1: APB4 completer response.

Function
REQ-011 SHALL accept an address phase when HSEL & HTRANS[1] & HREADY, and capture HADDR, HWRITE, HSIZE at that edge.
REQ-012 SHALL answer IDLE/BUSY transfers or unselected cycles with zero wait states, OKAY, and no APB activity.
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS, ERR1, ERR2.
REQ-014 IDLE->SETUP on accept; SETUP->ACCESS unconditionally; ACCESS stays while PREADY=0.
REQ-015 ACCESS with PREADY=1, PSLVERR=0 -> SETUP if a new accept occurs in that cycle, else IDLE.
REQ-016 ACCESS with PREADY=1, PSLVERR=1 -> ERR1; ERR1->ERR2; ERR2 -> SETUP on accept, else IDLE.
REQ-017 SETUP: PSEL=1, PENABLE=0, HREADYOUT=0; ACCESS: PSEL=1, PENABLE=1, HREADYOUT=PREADY & ~PSLVERR.
REQ-018 ERR1: HREADYOUT=0, HRESP=1; ERR2: HREADYOUT=1, HRESP=1; PSEL=PENABLE=0 in both.
REQ-019 Minimum latency: an accepted transfer with PREADY=1 completes in the second cycle after acceptance (exactly one wait state).
REQ-020 PADDR, PWRITE, PSTRB SHALL be registered at accept and held stable through SETUP and ACCESS.
REQ-021 PWDATA SHALL equal HWDATA (data phase held stable by the master while HREADYOUT=0).
REQ-022 PSTRB for writes: HSIZE=0 -> 4'b0001<<HADDR[1:0]; HSIZE=1 -> 4'b0011<<{HADDR[1],1'b0}; HSIZE=2 -> 4'b1111; reads -> 4'b0000.
REQ-023 HSIZE>2 SHALL skip APB entirely: accept -> ERR1 -> ERR2 (PSEL never asserted).
REQ-024 HRDATA SHALL equal PRDATA in ACCESS and 32'h0 otherwise.
REQ-025 HRESP SHALL be 0 in all states except ERR1/ERR2.
REQ-026 Back-to-back transfers SHALL have no IDLE gap: PSEL remains 1 across ACCESS->SETUP, with PENABLE dropping to 0.

Reset
REQ-027 HRESET=1 at an edge SHALL force IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PSTRB=0, HREADYOUT=1, HRESP=0, and clear the timeout counter.
REQ-028 Reset asserted during SETUP or ACCESS SHALL drop PSEL/PENABLE at that edge with no completion or error response.
REQ-029 The first cycle after reset release SHALL accept a new address phase.

Configuration
REQ-030 Macro APB_TIMEOUT_EN defined: an 8-bit-or-wider counter clears on SETUP->ACCESS and increments each ACCESS cycle with PREADY=0.
REQ-031 With APB_TIMEOUT_EN, the counter reaching TIMEOUT_CYCLES with PREADY=0 SHALL force ACCESS->ERR1 and deassert PSEL/PENABLE.
REQ-032 APB_TIMEOUT_EN undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Verification
REQ-033 Word write to 0x4000_0010, data 0xA5A5_5A5A, PREADY=1 -> PADDR=0x0010, PSTRB=4'hF, PWRITE=1, one wait state, HRESP=0.
REQ-034 Byte write to 0x4000_0003, then halfword write to 0x4000_0002 -> PSTRB=4'b1000, then 4'b1100.
REQ-035 Read with PREADY low for 3 ACCESS cycles, PRDATA=0xDEAD_BEEF -> HREADYOUT low for 4 cycles, HRDATA=0xDEAD_BEEF on the completion cycle.
REQ-036 PSLVERR=1 on a read -> HREADYOUT 0 then 1 with HRESP=1 for both cycles; HSIZE=3 -> same response, PSEL never 1.
REQ-037 Two back-to-back reads -> PSEL held high for 4 cycles, PENABLE pattern 0,1,0,1.
REQ-038 APB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and PREADY held 0 -> ERR1 after 4 ACCESS cycles; reset pulsed in ACCESS -> PSEL=0 on the next cycle.
